// File: rtl/adc_thermo_sampler.sv
// ---------------------------------------------------------------------------
// adc_thermo_sampler
//   Samples the 4-comparator ladder thermometer code for the ADC back end.
//   The asynchronous comparator outputs are synchronised into clk.
//   A programmable tick samples the code and converts it to a level (0..4).
//   Non-thermometer (bubble) codes are flagged.
//   2^AVG_LOG2 samples are box-car averaged into a filtered level.
//
// Parameters
//   CLK_DIV      sample-tick period in clk cycles (>= 2)
//   AVG_LOG2     log2 of samples per averaging window (0..6)
//   SYNC_STAGES  flops in the comparator synchroniser chain (>= 2)
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   enable      in   run sampling; low = idle, partial window discarded
//   comp_in     in   [3:0] ladder comparator outputs, bit0 = lowest threshold
//   level_out   out  [2:0] latest sampled level, popcount of the code
//   sample_stb  out  one-cycle pulse when level_out updates
//   bubble_err  out  latest sample was not a thermometer code
//   avg_out     out  [2:0] window average, sum >> AVG_LOG2 (truncated)
//   avg_valid   out  one-cycle pulse when avg_out updates
//   err_count   out  [7:0] saturating bubble counter
//
// Optional feature
//   ADC_BUBBLE_CNT_EN  when defined, err_count counts bubble samples and
//                      saturates at 255; otherwise err_count is tied to 0.
// ---------------------------------------------------------------------------
module adc_thermo_sampler #(
   parameter int CLK_DIV     = 1000,
   parameter int AVG_LOG2    = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] comp_in,
   output logic [2:0] level_out,
   output logic       sample_stb,
   output logic       bubble_err,
   output logic [2:0] avg_out,
   output logic       avg_valid,
   output logic [7:0] err_count
);

   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int AW = 3 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;

   logic [3:0]    sync_q [SYNC_STAGES];
   logic [3:0]    sync_code;

   logic          tick;
   logic [2:0]    lvl;
   logic          bub;
   logic [AW-1:0] acc_next;

   function automatic logic [2:0] popcount4(input logic [3:0] c);
      logic [2:0] s;
      s = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         s = s + {2'b00, c[i]};
      end
      return s;
   endfunction

   // Comparator synchroniser chain
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= comp_in;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign sync_code = sync_q[SYNC_STAGES-1];

   always_comb begin
      tick     = (state == RUN) && enable && (presc == PRE_LAST);
      lvl      = popcount4(sync_code);
      acc_next = acc + AW'(lvl);
      case (sync_code)
         4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: bub = 1'b0;
         default:                                     bub = 1'b1;
      endcase
   end

   // Sequencer: prescaler, sampling and window accumulation.
   // The sampled code is converted on the tick edge itself, so the registered
   // level/bubble/average outputs appear in the cycle after the tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         presc      <= '0;
         acc        <= '0;
         cnt        <= '0;
         level_out  <= '0;
         bubble_err <= 1'b0;
         sample_stb <= 1'b0;
         avg_out    <= '0;
         avg_valid  <= 1'b0;
      end else begin
         sample_stb <= 1'b0;
         avg_valid  <= 1'b0;
         case (state)
            IDLE: begin
               presc <= '0;
               acc   <= '0;
               cnt   <= '0;
               if (enable) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (!enable) begin
                  // Partial window is discarded; a coincident tick is ignored.
                  state <= IDLE;
                  presc <= '0;
                  acc   <= '0;
                  cnt   <= '0;
               end else if (tick) begin
                  presc      <= '0;
                  level_out  <= lvl;
                  bubble_err <= bub;
                  sample_stb <= 1'b1;
                  if (cnt == CNT_LAST) begin
                     avg_out   <= 3'(acc_next >> AVG_LOG2);
                     avg_valid <= 1'b1;
                     acc       <= '0;
                     cnt       <= '0;
                  end else begin
                     acc <= acc_next;
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADC_BUBBLE_CNT_EN
   // Counts alongside the sample_stb/bubble_err update; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= '0;
      end else if (tick && bub && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_adc_thermo_sampler.sv
// ---------------------------------------------------------------------------
// tb_adc_thermo_sampler
//   Self-checking bench for adc_thermo_sampler (CLK_DIV=4, AVG_LOG2=2,
//   SYNC_STAGES=2). A behavioural model tracks the expected level, bubble
//   flag, window sum and bubble count per sample.
// ---------------------------------------------------------------------------
module tb_adc_thermo_sampler;

   localparam int CLK_DIV = 4;
   localparam int WIN     = 4;

`ifdef ADC_BUBBLE_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] comp_in = '0;
   logic [2:0] level_out;
   logic       sample_stb;
   logic       bubble_err;
   logic [2:0] avg_out;
   logic       avg_valid;
   logic [7:0] err_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   int m_sum = 0;
   int m_n   = 0;
   int m_err = 0;
   int exp_level = 0;
   int exp_bub   = 0;
   int exp_avg   = 0;
   bit first_after_en = 1'b0;

   adc_thermo_sampler #(
      .CLK_DIV    (CLK_DIV),
      .AVG_LOG2   (2),
      .SYNC_STAGES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .comp_in   (comp_in),
      .level_out (level_out),
      .sample_stb(sample_stb),
      .bubble_err(bubble_err),
      .avg_out   (avg_out),
      .avg_valid (avg_valid),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit is_bubble(input logic [3:0] c);
      return !(c inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
   endfunction

   task automatic model_reset();
      m_sum = 0; m_n = 0; m_err = 0;
      exp_level = 0; exp_bub = 0; exp_avg = 0;
   endtask

   // Drive one code, wait for its strobe and compare the sample against the model.
   task automatic take_sample(input logic [3:0] code);
      int n, stray, exp_wait, lvl;
      bit got, exp_v, bub;
      comp_in  = code;
      n        = 0;
      stray    = 0;
      got      = 1'b0;
      exp_wait = first_after_en ? CLK_DIV + 1 : CLK_DIV;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         if (sample_stb) got = 1'b1;
         else if (avg_valid) stray++;
      end
      first_after_en = 1'b0;

      lvl = $countones(code);
      bub = is_bubble(code);
      m_sum += lvl;
      m_n++;
      exp_v = (m_n == WIN);
      if (exp_v) begin
         exp_avg = m_sum / WIN;
         m_sum = 0;
         m_n = 0;
      end
      if (bub && m_err < 255) m_err++;
      exp_level = lvl;
      exp_bub   = bub;

      n_cmp++;
      if (!got) begin
         n_fail++;
         $display("FAIL sample_timeout code=%b: no sample_stb within %0d cycles", code, n);
      end
      n_cmp++;
      if (n !== exp_wait) begin
         n_fail++;
         $display("FAIL strobe_spacing code=%b: got %0d cycles, want %0d", code, n, exp_wait);
      end
      n_cmp++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL stray_avg_valid: %0d off-strobe pulses, want 0", stray);
      end
      n_cmp++;
      if (level_out !== 3'(exp_level)) begin
         n_fail++;
         $display("FAIL level_out code=%b: got %0d, want %0d", code, level_out, exp_level);
      end
      n_cmp++;
      if (bubble_err !== exp_bub[0]) begin
         n_fail++;
         $display("FAIL bubble_err code=%b: got %b, want %0d", code, bubble_err, exp_bub);
      end
      n_cmp++;
      if (avg_valid !== exp_v) begin
         n_fail++;
         $display("FAIL avg_valid code=%b: got %b, want %b", code, avg_valid, exp_v);
      end
      n_cmp++;
      if (avg_out !== 3'(exp_avg)) begin
         n_fail++;
         $display("FAIL avg_out code=%b: got %0d, want %0d", code, avg_out, exp_avg);
      end
      n_cmp++;
      if (err_count !== (CNT_EN ? 8'(m_err) : 8'h00)) begin
         n_fail++;
         $display("FAIL err_count: got %0d, want %0d", err_count, CNT_EN ? m_err : 0);
      end
   endtask

   // Idle cycles: no strobes, and level/average outputs hold.
   task automatic check_quiet(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         n_cmp++;
         if (sample_stb !== 1'b0 || avg_valid !== 1'b0 ||
             level_out !== 3'(exp_level) || avg_out !== 3'(exp_avg)) begin
            n_fail++;
            $display("FAIL %s cycle %0d: stb=%b avg_valid=%b level=%0d avg=%0d, want 0 0 %0d %0d",
                     tag, i, sample_stb, avg_valid, level_out, avg_out, exp_level, exp_avg);
         end
      end
   endtask

   task automatic start_enable();
      enable = 1'b1;
      first_after_en = 1'b1;
   endtask

   task automatic stop_enable();
      enable = 1'b0;
      m_sum = 0;
      m_n = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      comp_in = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (level_out !== 3'd0 || sample_stb !== 1'b0 || bubble_err !== 1'b0 ||
             avg_out !== 3'd0 || avg_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state cycle %0d: lvl=%0d stb=%b bub=%b avg=%0d av=%b err=%0d, want all 0",
                     i, level_out, sample_stb, bubble_err, avg_out, avg_valid, err_count);
         end
      end
      reset = 1'b0;
      enable = 1'b0;
      model_reset();
      check_quiet(3, "post_reset_idle");
   endtask

   task automatic test_steady();
      start_enable();
      for (int i = 0; i < 8; i++) take_sample(4'b0111);
   endtask

   task automatic test_window();
      logic [3:0] codes [4];
      codes = '{4'b1111, 4'b1111, 4'b0001, 4'b0000};
      for (int i = 0; i < 4; i++) take_sample(codes[i]);
      n_cmp++;
      if (avg_out !== 3'd2) begin
         n_fail++;
         $display("FAIL window_4410: avg_out got %0d, want 2", avg_out);
      end
   endtask

   task automatic test_bubble();
      logic [3:0] c;
      take_sample(4'b0101);
      n_cmp++;
      if (err_count !== (CNT_EN ? 8'd1 : 8'd0) || level_out !== 3'd2 || bubble_err !== 1'b1) begin
         n_fail++;
         $display("FAIL first_bubble: err=%0d lvl=%0d bub=%b, want err=%0d lvl=2 bub=1",
                  err_count, level_out, bubble_err, CNT_EN ? 1 : 0);
      end
      for (int i = 0; i < 300; i++) begin
         do c = 4'($urandom_range(15)); while (!is_bubble(c));
         take_sample(c);
      end
      n_cmp++;
      if (err_count !== (CNT_EN ? 8'd255 : 8'd0)) begin
         n_fail++;
         $display("FAIL err_saturate: got %0d, want %0d", err_count, CNT_EN ? 255 : 0);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) take_sample(4'($urandom_range(15)));
   endtask

   task automatic test_partial();
      // Realign to a fresh window
      stop_enable();
      check_quiet(4, "realign_idle");
      start_enable();
      take_sample(4'b1111);
      take_sample(4'b0011);
      stop_enable();
      check_quiet(12, "partial_discard");
      start_enable();
      for (int i = 0; i < 4; i++) take_sample(4'($urandom_range(15)));
      // enable falls exactly in a tick cycle: that tick must be ignored
      take_sample(4'b0001);
      repeat (3) @(negedge clk);
      stop_enable();
      check_quiet(10, "tick_enable_fall");
      start_enable();
      for (int i = 0; i < 4; i++) take_sample(4'b1111);
   endtask

   task automatic test_reset_mid();
      stop_enable();
      check_quiet(3, "pre_mid_idle");
      start_enable();
      for (int i = 0; i < 3; i++) take_sample(4'b0111);
      // now in the cycle after the 3rd tick; the closing tick is 3 cycles on
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (level_out !== 3'd0 || sample_stb !== 1'b0 || bubble_err !== 1'b0 ||
             avg_out !== 3'd0 || avg_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid cycle %0d: lvl=%0d stb=%b bub=%b avg=%0d av=%b err=%0d, want all 0",
                     i, level_out, sample_stb, bubble_err, avg_out, avg_valid, err_count);
         end
      end
      reset = 1'b0;
      model_reset();
      first_after_en = 1'b1;
      for (int i = 0; i < 4; i++) take_sample(4'b0011);
   endtask

   initial begin
      test_reset();
      test_steady();
      test_window();
      test_bubble();
      test_random();
      test_partial();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
